// File: rtl/aes_round_ctrl_if.sv
// Handshake and datapath-control bundle between requester, aes_round_ctrl and the round datapath.
// Carries the abort line only when AES_ROUND_CTRL_ABORT_EN is defined.
interface aes_round_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
`ifdef AES_ROUND_CTRL_ABORT_EN
  logic       abort;
`endif
  logic       ld_state;
  logic       ld_key;
  logic       round_en;
  logic [3:0] round_idx;
  logic       final_round;
  logic [7:0] rcon;
  logic       busy;

`ifdef AES_ROUND_CTRL_ABORT_EN
  modport slave  (input in_valid, out_ready, abort,
                  output in_ready, out_valid, ld_state, ld_key, round_en,
                         round_idx, final_round, rcon, busy);
  modport master (output in_valid, out_ready, abort,
                  input in_ready, out_valid, ld_state, ld_key, round_en,
                        round_idx, final_round, rcon, busy);
`else
  modport slave  (input in_valid, out_ready,
                  output in_ready, out_valid, ld_state, ld_key, round_en,
                         round_idx, final_round, rcon, busy);
  modport master (output in_valid, out_ready,
                  input in_ready, out_valid, ld_state, ld_key, round_en,
                        round_idx, final_round, rcon, busy);
`endif
endinterface

// File: rtl/aes_round_ctrl.sv
// Round sequencer for an iterative AES-128 datapath: accept, NUM_ROUNDS rounds, hold result.
// Optional abort input enabled by defining AES_ROUND_CTRL_ABORT_EN.
module aes_round_ctrl #(
  parameter int NUM_ROUNDS       = 10,
  parameter int CYCLES_PER_ROUND = 1
) (
  input  logic             clk,
  input  logic             rst,
  aes_round_ctrl_if.slave  bus
);
  localparam int SW = (CYCLES_PER_ROUND > 1) ? $clog2(CYCLES_PER_ROUND) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

  state_t        r_state, w_next;
  logic [3:0]    r_round_idx;
  logic [7:0]    r_rcon;
  logic [SW-1:0] r_sub_cnt;

  logic w_abort, w_in_ready, w_accept, w_last_sub, w_final, w_round_en;
  logic [7:0] w_rcon_nxt;

`ifdef AES_ROUND_CTRL_ABORT_EN
  assign w_abort = bus.abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_last_sub = (r_sub_cnt == SW'(CYCLES_PER_ROUND - 1));
  assign w_final    = (r_state == S_ROUND) && (r_round_idx == 4'(NUM_ROUNDS));
  // DONE with out_ready re-opens the input so a new block loads on the same edge the result leaves
  assign w_in_ready = !w_abort && ((r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready));
  assign w_accept   = bus.in_valid && w_in_ready && !rst;
  assign w_round_en = (r_state == S_ROUND) && w_last_sub && !w_abort && !rst;
  assign w_rcon_nxt = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1B : 8'h00);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_round_idx <= 4'd0;
      r_rcon      <= 8'h01;
      r_sub_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_round_idx <= 4'd1;
        r_rcon      <= 8'h01;
        r_sub_cnt   <= '0;
      end else if (w_next == S_IDLE) begin
        r_round_idx <= 4'd0;
        r_rcon      <= 8'h01;
        r_sub_cnt   <= '0;
      end else if (r_state == S_ROUND) begin
        if (w_round_en) begin
          // the final round leaves index and rcon in place for the DONE state
          if (!w_final) begin
            r_round_idx <= r_round_idx + 4'd1;
            r_rcon      <= w_rcon_nxt;
            r_sub_cnt   <= '0;
          end
        end else begin
          r_sub_cnt <= r_sub_cnt + SW'(1);
        end
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_ROUND;
      S_ROUND: begin
        if (w_abort)                    w_next = S_IDLE;
        else if (w_last_sub && w_final) w_next = S_DONE;
      end
      S_DONE: begin
        if (w_abort)            w_next = S_IDLE;
        else if (bus.out_ready) w_next = w_accept ? S_ROUND : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready    = w_in_ready;
    bus.out_valid   = (r_state == S_DONE);
    bus.ld_state    = w_accept;
    bus.ld_key      = w_accept;
    bus.round_en    = w_round_en;
    bus.round_idx   = r_round_idx;
    bus.final_round = w_final;
    bus.rcon        = r_rcon;
    bus.busy        = (r_state == S_ROUND) || (r_state == S_DONE);
  end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// Randomized bench for aes_round_ctrl: two instances (1 and 3 cycles per round) against a cycle-count model.
// Drives abort as well when AES_ROUND_CTRL_ABORT_EN is defined.
module tb_aes_round_ctrl;
  localparam int N = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_round_ctrl_if if0();
  aes_round_ctrl_if if1();

  aes_round_ctrl #(.NUM_ROUNDS(N), .CYCLES_PER_ROUND(1)) u0 (.clk(clk), .rst(rst), .bus(if0));
  aes_round_ctrl #(.NUM_ROUNDS(N), .CYCLES_PER_ROUND(3)) u1 (.clk(clk), .rst(rst), .bus(if1));

  int n_chk  = 0;
  int n_pass = 0;

  // round constants for rounds 1..15
  logic [7:0] rc_tab [15] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                              8'h1b, 8'h36, 8'h6c, 8'hd8, 8'hab, 8'h4d, 8'h9a};
  int  cpr     [2] = '{1, 3};
  bit  m_busy  [2];
  int  m_k     [2];
  int  n_done  [2];
  int  n_ren   [2];

  logic in_valid, out_ready, abort_v;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // model: a block in flight is described only by cycles elapsed since its accept
  task automatic check_dut(input int id, input logic rdy, input logic ov, input logic lds,
                           input logic ldk, input logic ren, input logic fin, input logic bsy,
                           input logic [3:0] idx, input logic [7:0] rc);
    int   c = cpr[id];
    int   r;
    logic e_rdy, e_ov, e_ren, e_fin, e_bsy, acc, done;
    int   e_idx;
    logic [7:0] e_rc;
    done = 1'b0;
    if (!m_busy[id]) begin
      e_rdy = 1'b1; e_ov = 1'b0; e_idx = 0; e_rc = 8'h01; e_bsy = 1'b0; e_ren = 1'b0; e_fin = 1'b0;
    end else if (m_k[id] <= N * c) begin
      r     = (m_k[id] - 1) / c + 1;
      e_idx = r; e_rc = rc_tab[r-1];
      e_ren = ((m_k[id] - 1) % c) == (c - 1);
      e_fin = (r == N);
      e_rdy = 1'b0; e_ov = 1'b0; e_bsy = 1'b1;
    end else begin
      done  = 1'b1;
      e_ov  = 1'b1; e_idx = N; e_rc = rc_tab[N-1];
      e_rdy = out_ready; e_bsy = 1'b1; e_fin = 1'b0; e_ren = 1'b0;
    end
    if (abort_v) begin e_rdy = 1'b0; e_ren = 1'b0; end
    if (rst) e_ren = 1'b0;
    acc = in_valid && e_rdy && !rst;

    chk($sformatf("u%0d.in_ready", id),    32'(rdy), 32'(e_rdy));
    chk($sformatf("u%0d.out_valid", id),   32'(ov),  32'(e_ov));
    chk($sformatf("u%0d.ld_state", id),    32'(lds), 32'(acc));
    chk($sformatf("u%0d.ld_key", id),      32'(ldk), 32'(acc));
    chk($sformatf("u%0d.round_en", id),    32'(ren), 32'(e_ren));
    chk($sformatf("u%0d.final_round", id), 32'(fin), 32'(e_fin));
    chk($sformatf("u%0d.busy", id),        32'(bsy), 32'(e_bsy));
    chk($sformatf("u%0d.round_idx", id),   32'(idx), 32'(e_idx));
    chk($sformatf("u%0d.rcon", id),        32'(rc),  32'(e_rc));

    if (e_ren) n_ren[id]++;
    if (rst)                          m_busy[id] = 1'b0;
    else if (abort_v && m_busy[id])   m_busy[id] = 1'b0;
    else if (acc) begin               m_busy[id] = 1'b1; m_k[id] = 1; if (done) n_done[id]++; end
    else if (done && out_ready) begin m_busy[id] = 1'b0; n_done[id]++; end
    else if (m_busy[id] && !done)     m_k[id]++;
  endtask

  task automatic drive();
    if0.in_valid = in_valid; if0.out_ready = out_ready;
    if1.in_valid = in_valid; if1.out_ready = out_ready;
`ifdef AES_ROUND_CTRL_ABORT_EN
    if0.abort = abort_v; if1.abort = abort_v;
`endif
  endtask

  task automatic check_all();
    check_dut(0, if0.in_ready, if0.out_valid, if0.ld_state, if0.ld_key, if0.round_en,
              if0.final_round, if0.busy, if0.round_idx, if0.rcon);
    check_dut(1, if1.in_ready, if1.out_valid, if1.ld_state, if1.ld_key, if1.round_en,
              if1.final_round, if1.busy, if1.round_idx, if1.rcon);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; abort_v = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    for (int i = 0; i < 2; i++) begin m_busy[i] = 1'b0; m_k[i] = 0; n_done[i] = 0; n_ren[i] = 0; end

    // idle after reset with no request
    @(negedge clk); rst = 1'b0; drive(); #1 check_all();

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 3) != 0);
      // alternate windows of heavy backpressure and free-flowing output
      out_ready = cyc[7] ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 299) == 0) ||
            (m_busy[0] && m_k[0] == 5 && $urandom_range(0, 7) == 0);
`ifdef AES_ROUND_CTRL_ABORT_EN
      abort_v = ($urandom_range(0, 79) == 0);
`endif
      drive();
      #1 check_all();
    end

    chk("u0.blocks_completed", 32'(n_done[0] > 20), 32'd1);
    chk("u1.blocks_completed", 32'(n_done[1] > 5),  32'd1);
    chk("u1.round_pulses",     32'(n_ren[1] > 50),  32'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
Sequencer for an iterative AES-128 round datapath (state register, key register, one round function, on-the-fly key expansion). It accepts one plaintext/key block through a valid/ready handshake and steps the datapath through the initial AddRoundKey and NUM_ROUNDS rounds. It supplies round index, final-round flag and round constant, then presents the result through an output valid/ready handshake. It sits between the block-level request interface and the aes_encrypt round datapath.

Parameters:
NUM_ROUNDS, 10, number of cipher rounds (AES-128 = 10; range 1..15)
CYCLES_PER_ROUND, 1, clock cycles per round for a multicycle round function (range 1..4)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  requester has plaintext/key on the datapath inputs
in_ready  output  1  controller accepts a block this cycle
out_valid  output  1  ciphertext in the datapath state register is valid
out_ready  input  1  consumer takes the ciphertext this cycle
ld_state  output  1  load state reg with data_in XOR key (initial AddRoundKey)
ld_key  output  1  load key reg with cipher key
round_en  output  1  update state and key regs with the round result this cycle
round_idx  output  4  current round, 1..NUM_ROUNDS; 0 when idle
final_round  output  1  current round is the last (datapath skips MixColumns)
rcon  output  8  round constant for the key expansion of round_idx
busy  output  1  block in flight (ROUND or DONE)

Behaviour:
- States: IDLE, ROUND, DONE. rst has priority over every other event. On rst: IDLE, out_valid=0, round_idx=0, rcon=8'h01, sub-counter=0, busy=0.
- Accept = in_valid & in_ready. in_ready = (IDLE) | (DONE & out_ready); combinational.
- Accept cycle: ld_state=ld_key=1 (combinational, that cycle only). Next state ROUND; round_idx<=1, rcon<=8'h01, sub_cnt<=0.
- ROUND: sub_cnt counts 0..CYCLES_PER_ROUND-1. round_en=1 only when sub_cnt==CYCLES_PER_ROUND-1. final_round = ROUND & (round_idx==NUM_ROUNDS).
- On round_en, not final: round_idx++, rcon<=xtime(rcon) (shift left 1, XOR 8'h1B if bit7 was set), sub_cnt<=0. Sequence over 10 rounds: 01,02,04,08,10,20,40,80,1B,36.
- On round_en, final: go to DONE. round_idx and rcon hold.
- DONE: out_valid=1 and held stable until out_ready.
  - out_ready without accept: go to IDLE, round_idx<=0, rcon<=8'h01.
  - out_ready with in_valid: back-to-back accept in the same cycle. Result is read and the new block loaded at the same edge. Go to ROUND with round_idx=1. No idle bubble.
- Latency: out_valid rises NUM_ROUNDS*CYCLES_PER_ROUND+1 cycles after the accept cycle (11 for defaults). Peak throughput is one block per that many cycles.
- in_valid during ROUND is ignored (in_ready=0). Requester must hold data_in/key stable only in the accept cycle.
- ld_state, ld_key, round_en are never asserted outside the cases above, and never together with rst.
- busy = (ROUND | DONE).
- rst mid-operation: block discarded, no out_valid; IDLE values on the next cycle.

Optional Feature:
Macro AES_ROUND_CTRL_ABORT_EN.
- Defined: adds input port abort (1 bit), placed after out_ready.
  - abort in ROUND or DONE: next state IDLE, out_valid=0 from the next cycle, round_idx=0, rcon=8'h01, no further round_en.
  - abort forces in_ready=0 that cycle, so no accept happens, including the DONE back-to-back case.
  - abort in IDLE has no effect other than blocking accept.
  - rst still has priority over abort.
- Not defined: the port is absent and behaviour is exactly as above.

Test Plan:
1. Reset: rst=1 for 2 cycles, then 0 -> in_ready=1, out_valid=0, busy=0, round_idx=0, rcon=8'h01, no ld_*/round_en pulses.
2. FIPS-197 vector, defaults, with round datapath attached: pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c.
   -> Ciphertext 3925841d02dc09fbdc118597196a0b32.
   -> out_valid exactly 11 cycles after accept; rcon 01..36 in order; final_round high only at round_idx=10.
3. Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, round_idx=10 and ciphertext stable; in_ready=0.
   Then out_ready=1 with in_valid=1 -> same-cycle accept with ld_state=1, next out_valid 11 cycles later.
4. CYCLES_PER_ROUND=3 -> round_en every 3rd ROUND cycle (10 pulses total), out_valid 31 cycles after accept, same ciphertext as scenario 2.
5. rst asserted at round_idx=5 -> next cycle IDLE with reset values; out_valid never rises for that block. A new accept then completes normally.
6. AES_ROUND_CTRL_ABORT_EN defined: abort at round_idx=3 -> IDLE next cycle, no out_valid. abort together with in_valid in IDLE -> in_ready=0, no accept.
